// File: rtl/matvec_ram_engine_pkg.sv
// matvec_ram_engine shared package
// FSM states, RAM timing constants and default widths
package matvec_ram_engine_pkg;

   typedef enum logic [1:0] {
      ISSUE,
      DRAIN,
      COMMIT_WAIT,
      DONE
   } mv_state_t;

   // registered read data appears one cycle after the request
   localparam int RAM_RD_LAT = 1;
   // the RAM holds a write request one cycle before the array write
   localparam int RAM_WR_DLY = 1;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;

   function automatic int min_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matvec_ram_engine_index.sv
// mv_index_counter: nested row/column walker over an N x M matrix
// k is the flat row-major index; done flags the final issue
module mv_index_counter
   import matvec_ram_engine_pkg::*;
#(
   parameter int N  = 3,
   parameter int M  = 3,
   parameter int IW = min_width(N),
   parameter int JW = min_width(M),
   parameter int KW = min_width(N * M)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [IW-1:0] i,
   output logic [JW-1:0] j,
   output logic [KW-1:0] k,
   output logic          first,
   output logic          last,
   output logic          done
);

   assign first = (j == '0);
   assign last  = (j == JW'(M - 1));
   assign done  = en && last && (i == IW'(N - 1));

   // advance column, roll into next row, wrap everything after the final index
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (en) begin
         if (last) begin
            j <= '0;
            i <= (i == IW'(N - 1)) ? '0 : i + 1'b1;
         end else begin
            j <= j + 1'b1;
         end
         k <= done ? '0 : k + 1'b1;
      end
   end

endmodule

// File: rtl/matvec_ram_engine.sv
// matvec_ram_engine: computes y = A*x out of the scratch RAM
// one MAC per cycle, results written back, valid once committed
module matvec_ram_engine
   import matvec_ram_engine_pkg::*;
#(
   parameter int N          = 3,
   parameter int M          = 3,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int MAT_BASE   = 0,
   parameter int VEC_BASE   = N * M,
   parameter int OUT_BASE   = N * M + M
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] raddr_0,
   output logic                  ren_0,
   input  logic [DATA_WIDTH-1:0] rdata_0,
   output logic [ADDR_WIDTH-1:0] raddr_1,
   output logic                  ren_1,
   input  logic [DATA_WIDTH-1:0] rdata_1,
   output logic [ADDR_WIDTH-1:0] waddr_0,
   output logic [DATA_WIDTH-1:0] wdata_0,
   output logic                  wen_0,
   output logic                  valid
);

   localparam int IW    = min_width(N);
   localparam int JW    = min_width(M);
   localparam int KW    = min_width(N * M);
   localparam int CWAIT = RAM_WR_DLY + 1;
   localparam int CW_W  = min_width(CWAIT);
   localparam int TL    = RAM_RD_LAT;

   typedef struct packed {
      logic          vld;
      logic          first;
      logic          last;
      logic [IW-1:0] row;
   } tag_t;

   mv_state_t             state;
   logic [CW_W-1:0]       cw_cnt;
   tag_t [TL:0]           tp;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] prod;
   logic [DATA_WIDTH-1:0] mac;
   logic                  early_vld;

   logic                  cnt_en;
   logic                  cnt_clr;
   logic [IW-1:0]         idx_i;
   logic [JW-1:0]         idx_j;
   logic [KW-1:0]         idx_k;
   logic                  idx_first;
   logic                  idx_last;
   logic                  idx_done;

   assign cnt_en  = (state == ISSUE);
   assign cnt_clr = (state == DONE);

   mv_index_counter #(
      .N  (N),
      .M  (M),
      .IW (IW),
      .JW (JW),
      .KW (KW)
   ) u_idx (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .i     (idx_i),
      .j     (idx_j),
      .k     (idx_k),
      .first (idx_first),
      .last  (idx_last),
      .done  (idx_done)
   );

   // truncated product plus running sum; a row's first term restarts it
   always_comb begin
      prod = rdata_0 * rdata_1;
      mac  = (tp[TL].first ? '0 : acc) + prod;
   end

   // any tag still in flight ahead of the one meeting read data
   always_comb begin
      early_vld = 1'b0;
      for (int s = 0; s < TL; s++) begin
         early_vld = early_vld | tp[s].vld;
      end
   end

   // FSM, issue registers, tag pipe, accumulator and write register
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ISSUE;
         cw_cnt  <= '0;
         tp      <= '0;
         acc     <= '0;
         ren_0   <= 1'b0;
         ren_1   <= 1'b0;
         raddr_0 <= '0;
         raddr_1 <= '0;
         wen_0   <= 1'b0;
         waddr_0 <= '0;
         wdata_0 <= '0;
         valid   <= 1'b0;
      end else begin
         ren_0   <= 1'b0;
         ren_1   <= 1'b0;
         raddr_0 <= '0;
         raddr_1 <= '0;
         wen_0   <= 1'b0;
         waddr_0 <= '0;
         wdata_0 <= '0;
         tp[0]   <= '0;
         for (int s = 1; s <= TL; s++) begin
            tp[s] <= tp[s-1];
         end

         if (tp[TL].vld) begin
            acc <= mac;
            if (tp[TL].last) begin
               wen_0   <= 1'b1;
               waddr_0 <= ADDR_WIDTH'(OUT_BASE)
                        + ADDR_WIDTH'(tp[TL].row);
               wdata_0 <= mac;
            end
         end

         unique case (state)
            ISSUE: begin
               ren_0   <= 1'b1;
               ren_1   <= 1'b1;
               raddr_0 <= ADDR_WIDTH'(MAT_BASE)
                        + ADDR_WIDTH'(idx_k);
               raddr_1 <= ADDR_WIDTH'(VEC_BASE)
                        + ADDR_WIDTH'(idx_j);
               tp[0]   <= {1'b1, idx_first, idx_last, idx_i};
               if (idx_done) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (tp[TL].vld && !early_vld) begin
                  state  <= COMMIT_WAIT;
                  cw_cnt <= '0;
               end
            end
            COMMIT_WAIT: begin
               if (cw_cnt == CW_W'(CWAIT - 1)) begin
                  state <= DONE;
                  valid <= 1'b1;
               end else begin
                  cw_cnt <= cw_cnt + 1'b1;
               end
            end
            DONE: begin
               valid <= 1'b1;
            end
         endcase
      end
   end

endmodule
